// File: rtl/ack_bus_pkg.sv
// Shared widths, defaults and pointer helper for the acknowledgment bus.
package ack_bus_pkg;

   localparam int ACK_ID_W            = 2;
   localparam int ACK_NUM_MODULES     = 4;
   localparam int ACK_TIMEOUT_DEFAULT = 255;

   // Round-robin successor of a winner index among n sources.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/ack_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above i_ptr, with wrap-around.
// Zero latency; no state and no backpressure, grant is qualified by the caller.
module ack_rr_arbiter
   import ack_bus_pkg::*;
#(
   parameter int N     = ACK_NUM_MODULES,
   parameter int IDX_W = $clog2(ACK_NUM_MODULES)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [IDX_W-1:0] w_sel;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_sel   = '0;
      for (int k = 0; k < N; k++) begin
         w_sel = IDX_W'((int'(i_ptr) + k) % N);
         if (!o_any && i_req[w_sel]) begin
            o_any          = 1'b1;
            o_grant[w_sel] = 1'b1;
            o_idx          = w_sel;
         end
      end
   end

endmodule

// File: rtl/ack_bus_collector.sv
// Collects module acks round-robin into a one-entry output register; 1-cycle latency, no bubble when drained.
// ACK_READY drops while the register is full and not drained; ACK_BUS_TIMEOUT_EN adds a sticky stall flag.
module ack_bus_collector
   import ack_bus_pkg::*;
#(
   parameter int NUM_MODULES    = ACK_NUM_MODULES,
   parameter int ID_W           = ACK_ID_W,
   parameter int TIMEOUT_CYCLES = ACK_TIMEOUT_DEFAULT
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [NUM_MODULES-1:0]      ACK_VALID,
   input  logic [NUM_MODULES*ID_W-1:0] MODULE_SOURCE_ID,
   output logic [NUM_MODULES-1:0]      ACK_READY,
   output logic                        ACK_OUT_VALID,
   input  logic                        ACK_OUT_READY,
   output logic [ID_W-1:0]             ACK_OUT_ID,
   output logic                        ACK_TIMEOUT
);

   localparam int PTR_W = $clog2(NUM_MODULES);

   logic [PTR_W-1:0]       r_ptr;
   logic                   r_out_vld;
   logic [ID_W-1:0]        r_out_id;
   logic [NUM_MODULES-1:0] w_grant;
   logic [PTR_W-1:0]       w_win_idx;
   logic                   w_any;
   logic                   w_can_accept;
   logic                   w_mod_hs;
   logic [PTR_W-1:0]       w_ptr_nxt;

   ack_rr_arbiter #(
      .N     (NUM_MODULES),
      .IDX_W (PTR_W)
   ) u_arb (
      .i_req   (ACK_VALID),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_win_idx),
      .o_any   (w_any)
   );

   // Draining and refilling in the same cycle keeps full throughput.
   assign w_can_accept = ~r_out_vld | ACK_OUT_READY;
   assign w_mod_hs     = w_any & w_can_accept;
   assign ACK_READY    = w_can_accept ? w_grant : '0;
   assign w_ptr_nxt    = PTR_W'(rr_next(int'(w_win_idx), NUM_MODULES));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ptr     <= '0;
         r_out_vld <= 1'b0;
         r_out_id  <= '0;
      end else if (w_mod_hs) begin
         r_out_vld <= 1'b1;
         r_out_id  <= MODULE_SOURCE_ID[w_win_idx*ID_W +: ID_W];
         r_ptr     <= w_ptr_nxt;
      end else if (ACK_OUT_READY) begin
         r_out_vld <= 1'b0;
      end
   end

   assign ACK_OUT_VALID = r_out_vld;
   assign ACK_OUT_ID    = r_out_id;

`ifdef ACK_BUS_TIMEOUT_EN
   localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_stall_cnt;
   logic             r_timeout;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_stall_cnt <= '0;
         r_timeout   <= 1'b0;
      end else begin
         if (r_stall_cnt == CNT_MAX)
            r_timeout <= 1'b1;
         if (!r_out_vld || ACK_OUT_READY)
            r_stall_cnt <= '0;
         else if (r_stall_cnt != CNT_MAX)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign ACK_TIMEOUT = r_timeout;
`else
   assign ACK_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_ack_bus_collector.sv
module tb_ack_bus_collector;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] ACK_VALID = 4'b0000;
   logic [7:0] MODULE_SOURCE_ID;
   logic [3:0] ACK_READY;
   logic       ACK_OUT_VALID;
   logic       ACK_OUT_READY = 1'b0;
   logic [1:0] ACK_OUT_ID;
   logic       ACK_TIMEOUT;

`ifdef ACK_BUS_TIMEOUT_EN
   localparam logic EXP_TO = 1'b1;
`else
   localparam logic EXP_TO = 1'b0;
`endif

   // module ids: m0=11, m1=00, m2=10, m3=01
   assign MODULE_SOURCE_ID = 8'b01_10_00_11;

   always #5 CLK = ~CLK;

   ack_bus_collector #(
      .NUM_MODULES    (4),
      .ID_W           (2),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .CLK              (CLK),
      .RST              (RST),
      .ACK_VALID        (ACK_VALID),
      .MODULE_SOURCE_ID (MODULE_SOURCE_ID),
      .ACK_READY        (ACK_READY),
      .ACK_OUT_VALID    (ACK_OUT_VALID),
      .ACK_OUT_READY    (ACK_OUT_READY),
      .ACK_OUT_ID       (ACK_OUT_ID),
      .ACK_TIMEOUT      (ACK_TIMEOUT)
   );

   typedef struct {
      logic [3:0] vld;
      logic       out_rdy;
      logic [3:0] exp_rdy;
      logic       exp_out_vld;
      logic [1:0] exp_out_id;
   } vec_t;

   vec_t tbl [23];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic [3:0] v, input logic r);
      @(negedge CLK);
      ACK_VALID     = v;
      ACK_OUT_READY = r;
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [3:0] er, input logic ev, input logic [1:0] eid);
      chk({tag, "_ack_ready"}, 32'(ACK_READY), 32'(er));
      chk({tag, "_out_valid"}, 32'(ACK_OUT_VALID), 32'(ev));
      chk({tag, "_out_id"}, 32'(ACK_OUT_ID), 32'(eid));
   endtask

   task automatic pulse_rst();
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   initial begin
      // single request, rotation 0..3,0, stall with 1 and 3 pending, empty-register accept, wrap
      tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'b00};
      tbl[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'b00};
      tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'b10};
      tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 2'b10};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'b01};
      tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'b11};
      tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'b00};
      tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'b10};
      tbl[8]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'b01};
      tbl[9]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'b11};
      tbl[10] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'b11};
      tbl[11] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'b11};
      tbl[12] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'b11};
      tbl[13] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'b11};
      tbl[14] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'b11};
      tbl[15] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'b00};
      tbl[16] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'b00};
      tbl[17] = '{4'b0011, 1'b0, 4'b0000, 1'b1, 2'b01};
      tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'b01};
      tbl[19] = '{4'b0011, 1'b0, 4'b0001, 1'b0, 2'b01};
      tbl[20] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'b11};
      tbl[21] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'b11};
      tbl[22] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'b11};

      repeat (2) @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("reset_timeout", 32'(ACK_TIMEOUT), 32'd0);

      for (int i = 0; i < 23; i++) begin
         apply(tbl[i].vld, tbl[i].out_rdy);
         check_outs($sformatf("vec%0d", i), tbl[i].exp_rdy, tbl[i].exp_out_vld, tbl[i].exp_out_id);
      end

      // reset while module 0 waits and the pointer sits at 3
      apply(4'b0100, 1'b0);
      check_outs("rst_pre_load", 4'b0100, 1'b0, 2'b11);
      apply(4'b1001, 1'b0);
      check_outs("rst_pre_full", 4'b0000, 1'b1, 2'b10);
      pulse_rst();
      #1;
      check_outs("rst_post", 4'b0001, 1'b0, 2'b00);
      apply(4'b1001, 1'b1);
      check_outs("rst_regrant", 4'b1000, 1'b1, 2'b11);

      // 7-cycle stall must not trip the timeout
      apply(4'b0000, 1'b0);
      pulse_rst();
      apply(4'b0001, 1'b0);
      check_outs("to7_load", 4'b0001, 1'b0, 2'b00);
      for (int i = 0; i < 7; i++) begin
         apply(4'b0000, 1'b0);
         chk($sformatf("to7_stall%0d_valid", i), 32'(ACK_OUT_VALID), 32'd1);
      end
      apply(4'b0000, 1'b1);
      apply(4'b0000, 1'b0);
      chk("to7_drained", 32'(ACK_OUT_VALID), 32'd0);
      chk("to7_timeout", 32'(ACK_TIMEOUT), 32'd0);

      // 8-cycle stall trips it, sticky after the drain
      apply(4'b0001, 1'b0);
      check_outs("to8_load", 4'b0001, 1'b0, 2'b11);
      for (int i = 0; i < 8; i++) begin
         apply(4'b0000, 1'b0);
         chk($sformatf("to8_stall%0d_valid", i), 32'(ACK_OUT_VALID), 32'd1);
      end
      apply(4'b0000, 1'b1);
      chk("to8_at_limit", 32'(ACK_TIMEOUT), 32'd0);
      apply(4'b0000, 1'b0);
      chk("to8_drained", 32'(ACK_OUT_VALID), 32'd0);
      chk("to8_timeout", 32'(ACK_TIMEOUT), 32'(EXP_TO));
      apply(4'b0000, 1'b0);
      apply(4'b0000, 1'b1);
      chk("to8_sticky", 32'(ACK_TIMEOUT), 32'(EXP_TO));
      pulse_rst();
      #1;
      chk("to_reset_clear", 32'(ACK_TIMEOUT), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
